div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle controller for the M-extension divide/remainder ops: div, divu, rem, remu (aluControl 5'h0e, 5'h0f, 5'h10, 5'h11).
- Sits beside the single-cycle ALU and stalls the core while it runs.
- Sequences a radix-2 restoring divider over WIDTH iterations using a start/stall/done handshake.
- Handles the RISC-V divide-by-zero and signed-overflow cases without iterating.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  core requests an op this cycle; sampled only in IDLE.
- aluControl  in  5  decoded ALU op code; only 5'h0e..5'h11 launch the sequencer.
- srcA  in  WIDTH  dividend; captured on accepted start.
- srcB  in  WIDTH  divisor; captured on accepted start.
- stall  out  1  freeze PC/register writeback while high.
- busy  out  1  sequencer not in IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; count, result, and internal quotient/remainder/divisor registers = 0; busy=0; done=0; stall=0.
- isDiv = aluControl in {0e,0f,10,11}; signed = aluControl in {0e,10}; wantRem = aluControl in {10,11}.
- States:
  - IDLE: accepted start = start & isDiv. Operands, op, and signs are latched.
    - Special case, srcB==0: next state DONE, result = wantRem ? srcA : all-ones.
    - Special case, signed & srcA==MIN & srcB==-1: next state DONE, result = wantRem ? 0 : MIN.
    - Otherwise next state INIT.
    - start with non-div aluControl is ignored: stays IDLE, no register changes.
  - INIT (1 cycle): load |dividend| into Q and |divisor| into D for signed ops (raw values for unsigned); R=0; count=0.
  - ITER (WIDTH cycles): R' = {R[WIDTH-1:0], Q[WIDTH-1]}; Q <<= 1; if R' >= D then R = R'-D and Q[0]=1, else R = R'. count increments. Leave after count==WIDTH-1.
    - R is WIDTH+1 bits; compare/subtract is unsigned.
  - FIXUP (1 cycle):
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend is negative.
    - result = wantRem ? rem : quot.
  - DONE (1 cycle): done=1, then go to IDLE. start is not accepted in DONE; the core reissues next cycle if needed.
- Latency from the accepted-start edge E0:
  - Normal op: done high during the cycle after edge E0+WIDTH+2, i.e. 35 cycles at WIDTH=32.
  - Special case: done high during the cycle after E0.
- stall = (state==IDLE & start & isDiv) | state in {INIT, ITER, FIXUP}.
  - stall is low in DONE so the core retires the instruction with result.
  - The core holds start/aluControl/srcA/srcB stable while stalled; the sequencer uses only its latched copies.
- busy = (state != IDLE).
- result changes only in FIXUP or on a special-case start; otherwise it holds its value.
- Reset asserted mid-ITER aborts immediately: outputs go to 0 and no done pulse is produced.
- Back-to-back ops: a start in the cycle after DONE (IDLE) is accepted normally.

Decomposition:
- Shared package (alu_pkg):
  - ALU control code constants ALU_DIV=5'h0e, ALU_DIVU=5'h0f, ALU_REM=5'h10, ALU_REMU=5'h11.
  - div_state_t enum {IDLE, INIT, ITER, FIXUP, DONE}.
- Sub-module div_step: combinational single restoring step.
  - Inputs: R, Q, D.
  - Outputs: R_next, Q_next.
  - Instantiated once inside the ITER datapath.
- count is $clog2(WIDTH) bits.

Test Plan:
- divu 100/7 (aluControl=0f): result=14, done exactly 35 cycles after start edge, stall high cycles 0..34 from start and low in DONE.
- div -100/7 (0e) -> -14 (0xFFFFFFF2); rem -100/7 (10) -> -2 (0xFFFFFFFE); remu 0xFFFFFFFF/16 (11) -> 15.
- Divide by zero:
  - div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5.
  - Both give done in the cycle after start, with ITER never entered.
- Signed overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0; 1-cycle latency.
- Ignored requests:
  - start with aluControl=5'h0 (add) -> state stays IDLE, stall=0.
  - start pulsed during ITER -> no restart; original result is delivered.
- Reset asserted at iteration 10 -> busy/stall/done/result=0 asynchronously; a new divu 9/3 after release returns 3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: M-extension divide op codes, the divide
// sequencer state encoding and small op-decode helpers.
package alu_pkg;

  localparam logic [4:0] ALU_DIV  = 5'h0e;
  localparam logic [4:0] ALU_DIVU = 5'h0f;
  localparam logic [4:0] ALU_REM  = 5'h10;
  localparam logic [4:0] ALU_REMU = 5'h11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  // True for any of the four divide/remainder ops.
  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  // True for the signed variants (div, rem).
  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

  // True when the remainder rather than the quotient is returned.
  function automatic logic is_rem_op(input logic [4:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r_next,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_d_ext;
  logic           w_fits;

  // Partial remainder is one bit wider than the divisor so the unsigned
  // compare/subtract never loses the shifted-out top bit.
  assign w_shift  = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_d_ext  = {1'b0, i_d};
  assign w_fits   = (w_shift >= w_d_ext);
  assign o_r_next = w_fits ? (w_shift - w_d_ext) : w_shift;
  assign o_q_next = {i_q[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle controller for div/divu/rem/remu. Runs a restoring divider
// for WIDTH iterations beside the single-cycle ALU, stalling the core
// until the result is ready. Divide-by-zero and signed overflow are
// resolved directly from the operands without iterating.
module div_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   COUNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_signed;
  logic             r_want_rem;
  logic [WIDTH-1:0] r_result;

  logic             w_is_div;
  logic             w_op_signed;
  logic             w_op_rem;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_special;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Decode of the incoming request; only meaningful while IDLE.
  assign w_is_div    = is_div_op(aluControl);
  assign w_op_signed = is_signed_op(aluControl);
  assign w_op_rem    = is_rem_op(aluControl);
  assign w_accept    = (r_state == IDLE) && start && w_is_div;
  assign w_div_zero  = (srcB == {WIDTH{1'b0}});
  assign w_overflow  = w_op_signed && (srcA == MIN_VAL) && (srcB == ALL_ONES);
  assign w_special   = w_div_zero || w_overflow;

  // Sign handling uses the latched operands so the core may change its
  // inputs once the op has been accepted.
  assign w_neg_a = r_signed && r_dividend[WIDTH-1];
  assign w_neg_b = r_signed && r_divisor[WIDTH-1];
  assign w_quot  = (w_neg_a ^ w_neg_b) ? -r_q : r_q;
  assign w_rem   = w_neg_a ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r      (r_r),
    .i_q      (r_q),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_q_next (w_q_next)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection; special cases skip straight to DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_special ? DONE : INIT;
        end else begin
          w_next_state = IDLE;
        end
      end
      INIT:  w_next_state = ITER;
      ITER: begin
        if (r_count == LAST_COUNT) begin
          w_next_state = FIXUP;
        end else begin
          w_next_state = ITER;
        end
      end
      FIXUP: w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs; stall drops in DONE so the core retires the result.
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      IDLE: begin
        stall = start && w_is_div;
        busy  = 1'b0;
      end
      INIT, ITER, FIXUP: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        stall = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration registers and result update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= {CW{1'b0}};
      r_q        <= {WIDTH{1'b0}};
      r_r        <= {(WIDTH+1){1'b0}};
      r_d        <= {WIDTH{1'b0}};
      r_dividend <= {WIDTH{1'b0}};
      r_divisor  <= {WIDTH{1'b0}};
      r_signed   <= 1'b0;
      r_want_rem <= 1'b0;
      r_result   <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dividend <= srcA;
            r_divisor  <= srcB;
            r_signed   <= w_op_signed;
            r_want_rem <= w_op_rem;
            if (w_div_zero) begin
              r_result <= w_op_rem ? srcA : ALL_ONES;
            end else if (w_overflow) begin
              r_result <= w_op_rem ? {WIDTH{1'b0}} : MIN_VAL;
            end
          end
        end
        INIT: begin
          r_q     <= w_neg_a ? -r_dividend : r_dividend;
          r_d     <= w_neg_b ? -r_divisor : r_divisor;
          r_r     <= {(WIDTH+1){1'b0}};
          r_count <= {CW{1'b0}};
        end
        ITER: begin
          r_r     <= w_r_next;
          r_q     <= w_q_next;
          r_count <= r_count + COUNT_ONE;
        end
        FIXUP: begin
          r_result <= r_want_rem ? w_rem : w_quot;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer: latency, stall profile, signed
// fixups, divide-by-zero, overflow, ignored requests and mid-op reset.
module tb_div_sequencer;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int NORMAL_LAT = W + 3;

  logic         clk;
  logic         reset;
  logic         start;
  logic [4:0]   aluControl;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int vectors;
  int miscompares;

  div_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .aluControl (aluControl),
    .srcA       (srcA),
    .srcB       (srcB),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for a single cycle; returns stall seen in that cycle.
  task automatic launch(input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic stall0);
    @(negedge clk);
    start = 1'b1; aluControl = op; srcA = a; srcB = b;
    #1;
    stall0 = stall;
    @(negedge clk);
    start = 1'b0; aluControl = 5'h00;
  endtask

  // Count cycles from the start cycle until done (bounded).
  task automatic wait_done(input int bound, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; aluControl = 5'h00; srcA = '0; srcB = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, stall, done} !== 3'b000 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b stall=%b done=%b result=%h expected 0", busy, stall, done, result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_timing();
    logic s0;
    int   bad;
    launch(ALU_DIVU, 32'd100, 32'd7, s0);
    vectors++;
    if (s0 !== 1'b1) begin
      miscompares++;
      $display("FAIL divu_stall_c0: got %b expected 1", s0);
    end
    bad = 0;
    for (int k = 1; k <= 34; k++) begin
      if (stall !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL divu_stall_window: got %0d bad cycles expected 0", bad);
    end
    vectors++;
    if (done !== 1'b1 || stall !== 1'b0 || result !== 32'd14) begin
      miscompares++;
      $display("FAIL divu_done_c35: got done=%b stall=%b result=%h expected done=1 stall=0 result=0000000e", done, stall, result);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd14) begin
      miscompares++;
      $display("FAIL divu_after_done: got done=%b busy=%b result=%h expected 0 0 0000000e", done, busy, result);
    end
  endtask

  // Ops table: normal ops plus special cases, with expected latency.
  task automatic test_ops();
    logic [4:0]   ops  [12] = '{ALU_DIV, ALU_REM, ALU_REMU, ALU_DIV, ALU_REM,
                                 ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU,
                                 ALU_DIV, ALU_REM, ALU_DIVU};
    logic [W-1:0] as   [12] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'd5, 32'd5, 32'd5, 32'd5,
                                 32'h80000000, 32'h80000000, 32'h80000000};
    logic [W-1:0] bs   [12] = '{32'd7, 32'd7, 32'd16, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                 32'd0, 32'd0, 32'd0, 32'd0,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] exps [12] = '{32'hFFFFFFF2, 32'hFFFFFFFE, 32'd15, 32'd3, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5,
                                 32'h80000000, 32'd0, 32'd0};
    int           lats [12] = '{NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, NORMAL_LAT,
                                 1, 1, 1, 1, 1, 1, NORMAL_LAT};
    logic s0;
    int   cyc;
    for (int i = 0; i < 12; i++) begin
      launch(ops[i], as[i], bs[i], s0);
      wait_done(60, cyc);
      vectors++;
      if (done !== 1'b1 || cyc != lats[i] || result !== exps[i] || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL op_%0d: got done=%b lat=%0d stall=%b result=%h expected done=1 lat=%0d stall=0 result=%h",
                 i, done, cyc, stall, result, lats[i], exps[i]);
      end
    end
  endtask

  task automatic test_ignored_add();
    logic [W-1:0] held;
    @(negedge clk);
    held = result;
    start = 1'b1; aluControl = 5'h00; srcA = 32'd9; srcB = 32'd0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL add_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== held) begin
      miscompares++;
      $display("FAIL add_ignored: got busy=%b done=%b result=%h expected 0 0 %h", busy, done, result, held);
    end
    start = 1'b0;
  endtask

  task automatic test_start_during_iter();
    logic s0;
    int   cyc;
    launch(ALU_DIVU, 32'd1000, 32'd10, s0);
    cyc = 1;
    repeat (4) begin @(negedge clk); cyc++; end
    start = 1'b1; aluControl = ALU_REM; srcA = 32'd7; srcB = 32'd0;
    @(negedge clk); cyc++;
    start = 1'b0; aluControl = 5'h00;
    while (done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    vectors++;
    if (done !== 1'b1 || cyc != NORMAL_LAT || result !== 32'd100) begin
      miscompares++;
      $display("FAIL start_in_iter: got done=%b lat=%0d result=%h expected done=1 lat=%0d result=00000064", done, cyc, result, NORMAL_LAT);
    end
  endtask

  task automatic test_reset_mid_iter();
    logic s0;
    int   pulses;
    int   cyc;
    launch(ALU_DIVU, 32'd123456, 32'd7, s0);
    repeat (11) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL iter10_busy: got busy=%b stall=%b expected 1 1", busy, stall);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({busy, stall, done} !== 3'b000 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b stall=%b done=%b result=%h expected 0", busy, stall, done, result);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL no_done_after_abort: got %0d pulses expected 0", pulses);
    end
    launch(ALU_DIVU, 32'd9, 32'd3, s0);
    wait_done(60, cyc);
    vectors++;
    if (done !== 1'b1 || cyc != NORMAL_LAT || result !== 32'd3) begin
      miscompares++;
      $display("FAIL divu_after_reset: got done=%b lat=%0d result=%h expected done=1 lat=%0d result=00000003", done, cyc, result, NORMAL_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic s0;
    int   cyc;
    launch(ALU_DIVU, 32'd50, 32'd5, s0);
    wait_done(60, cyc);
    vectors++;
    if (done !== 1'b1 || cyc != NORMAL_LAT || result !== 32'd10) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b lat=%0d result=%h expected done=1 lat=%0d result=0000000a", done, cyc, result, NORMAL_LAT);
    end
    launch(ALU_REMU, 32'd50, 32'd6, s0);
    vectors++;
    if (s0 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept_stall: got %b expected 1", s0);
    end
    wait_done(60, cyc);
    vectors++;
    if (done !== 1'b1 || cyc != NORMAL_LAT || result !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_second: got done=%b lat=%0d result=%h expected done=1 lat=%0d result=00000002", done, cyc, result, NORMAL_LAT);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_divu_timing();
    test_ops();
    test_ignored_add();
    test_start_during_iter();
    test_reset_mid_iter();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
